ins_fetch_buffer: RTL

INS_FETCH_BUFFER -- requirements
Module: ins_fetch_buffer

---
 rtl/ifu_pkg.sv | 22 ++
 rtl/fetch_line_buf.sv | 35 +++
 rtl/ins_fetch_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch buffer.
//   ifu_state_e    : fetch buffer controller states
//   DEF_LINE_WORDS : default number of words per buffered line
//   WORD_OFF_W     : word-offset width for the default line size
//   TAG_MSB/TAG_LSB: address bit range holding the line tag
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MREQ = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } ifu_state_e;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BYTE_OFF_W     = 2;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned WORD_OFF_W     = $clog2(DEF_LINE_WORDS);
  localparam int unsigned TAG_MSB        = ADDR_W - 1;
  localparam int unsigned TAG_LSB        = BYTE_OFF_W + WORD_OFF_W;

endpackage

// File: rtl/fetch_line_buf.sv
// Storage for one buffered instruction line.
//   clock_in / reset_in : clock, asynchronous active-low reset (clears all words)
//   wr_en, wr_idx, wr_data : indexed single-word write
//   rd_idx, rd_data        : combinational indexed read
module fetch_line_buf
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] words_q [LINE_WORDS];

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int unsigned i = 0; i < LINE_WORDS; i++) begin
        words_q[i] <= '0;
      end
    end else if (wr_en) begin
      words_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = words_q[rd_idx];

endmodule

// File: rtl/ins_fetch_buffer.sv
// Single-line instruction fetch buffer between the IFU and backing memory.
//   clock_in, reset_in (async, active-low)
//   req_valid_in / req_addr_in / req_ready_out : IFU fetch request
//   flush_in                                   : invalidate the buffered line
//   rsp_valid_out / rsp_ins_out / rsp_hit_out / rsp_err_out : one-cycle response
//   mem_req_valid_out / mem_req_ready_in / mem_addr_out     : line read request
//   mem_rvalid_in / mem_rdata_in : returned words, ascending order
// LINE_WORDS must be a power of two, at least 2.
module ins_fetch_buffer
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  req_valid_in,
  input  logic [ADDR_W-1:0]     req_addr_in,
  output logic                  req_ready_out,
  input  logic                  flush_in,
  output logic                  rsp_valid_out,
  output logic [DATA_WIDTH-1:0] rsp_ins_out,
  output logic                  rsp_hit_out,
  output logic                  rsp_err_out,
  output logic                  mem_req_valid_out,
  input  logic                  mem_req_ready_in,
  output logic [ADDR_W-1:0]     mem_addr_out,
  input  logic                  mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned TAG_LO = BYTE_OFF_W + OFF_W;
  localparam int unsigned TAG_W  = ADDR_W - TAG_LO;

  ifu_state_e state_q, state_d;

  logic [TAG_W-1:0]      req_tag_q;
  logic [OFF_W-1:0]      req_off_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  valid_q;
  logic                  flush_pend_q;
  logic [OFF_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] ins_q;
  logic                  hit_q;
  logic                  err_q;

  logic                  accept;
  logic                  misaligned;
  logic                  tag_match;
  logic                  fill_beat;
  logic                  fill_last;
  logic [OFF_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept     = req_valid_in && (state_q == IDLE);
  assign misaligned = |req_addr_in[BYTE_OFF_W-1:0];
  // A flush on the accepting edge wins over the lookup.
  assign tag_match  = valid_q && !flush_in && (tag_q == req_addr_in[ADDR_W-1:TAG_LO]);
  assign fill_beat  = (state_q == FILL) && mem_rvalid_in;
  assign fill_last  = fill_beat && (count_q == OFF_W'(LINE_WORDS - 1));
  // IDLE reads the incoming request's word for a hit; FILL reads the latched one.
  assign rd_idx     = (state_q == IDLE) ? req_addr_in[TAG_LO-1:BYTE_OFF_W] : req_off_q;

  fetch_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (OFF_W)
  ) u_line (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .wr_en    (fill_beat),
    .wr_idx   (count_q),
    .wr_data  (mem_rdata_in),
    .rd_idx   (rd_idx),
    .rd_data  (rd_word)
  );

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (misaligned || tag_match) ? RESP : MREQ;
      MREQ: if (mem_req_ready_in) state_d = FILL;
      FILL: if (fill_last) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      req_tag_q    <= '0;
      req_off_q    <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      count_q      <= '0;
      ins_q        <= '0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_in) valid_q <= 1'b0;
          if (accept) begin
            req_tag_q    <= req_addr_in[ADDR_W-1:TAG_LO];
            req_off_q    <= req_addr_in[TAG_LO-1:BYTE_OFF_W];
            flush_pend_q <= 1'b0;
            if (misaligned) begin
              ins_q <= '0;
              hit_q <= 1'b0;
              err_q <= 1'b1;
            end else if (tag_match) begin
              ins_q <= rd_word;
              hit_q <= 1'b1;
              err_q <= 1'b0;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        MREQ: begin
          if (flush_in) flush_pend_q <= 1'b1;
        end
        FILL: begin
          if (flush_in) flush_pend_q <= 1'b1;
          if (fill_beat) begin
            // count wraps back to zero after the last word
            count_q <= count_q + 1'b1;
            if (fill_last) begin
              tag_q   <= req_tag_q;
              valid_q <= !(flush_pend_q || flush_in);
              // the requested word may be the one arriving right now
              ins_q   <= (req_off_q == count_q) ? mem_rdata_in : rd_word;
              hit_q   <= 1'b0;
              err_q   <= 1'b0;
            end
          end
        end
        RESP: begin
          if (flush_in) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready_out     = (state_q == IDLE);
  assign rsp_valid_out     = (state_q == RESP);
  assign rsp_ins_out       = ins_q;
  assign rsp_hit_out       = hit_q;
  assign rsp_err_out       = err_q;
  assign mem_req_valid_out = (state_q == MREQ);
  assign mem_addr_out      = {req_tag_q, {TAG_LO{1'b0}}};

endmodule
